// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared state, phase and width constants for the processor core
package proc_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_COMMIT = 3'd4,
    S_HALTED = 3'd5,
    S_HOLD   = 3'd6
  } state_t;

  localparam logic [1:0] PH_FETCH  = 2'b00;
  localparam logic [1:0] PH_DECODE = 2'b01;
  localparam logic [1:0] PH_EXEC   = 2'b10;
  localparam logic [1:0] PH_COMMIT = 2'b11;

endpackage

// File: rtl/fetch_exec_sequencer.sv
// rtl/fetch_exec_sequencer.sv - FETCH/DECODE/EXEC/COMMIT sequencer with PC/IR strobes and retire counter
// Optional feature macro: SINGLE_STEP_EN (adds step input and a COMMIT-hold state).
module fetch_exec_sequencer
  import proc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mem_busy,
  input  logic             halt_ins,
  input  logic             jump_taken,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [1:0]       phase,
  output logic             ir_load,
  output logic             exec_en,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  state_t state, state_next;
  logic   step_rise;

`ifdef SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign step_rise = step & ~step_q;
`else
  assign step_rise = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Counts on the first COMMIT cycle only; the hold state never re-counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retired <= '0;
    else if (state == S_COMMIT && retired != {CNT_W{1'b1}})
      retired <= retired + 1'b1;
  end

  always_comb begin
    state_next = state;
    phase      = PH_FETCH;
    ir_load    = 1'b0;
    exec_en    = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    running    = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        running = 1'b1;
        phase   = PH_FETCH;
        ir_load = ~mem_busy;
        if (!mem_busy) state_next = S_DECODE;
      end
      S_DECODE: begin
        running    = 1'b1;
        phase      = PH_DECODE;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        running = 1'b1;
        phase   = PH_EXEC;
        exec_en = ~mem_busy;
        if (!mem_busy) state_next = S_COMMIT;
      end
      S_COMMIT: begin
        running = 1'b1;
        phase   = PH_COMMIT;
        // Halt wins over jump and leaves the PC on the END instruction.
        if (halt_ins) begin
          state_next = S_HALTED;
        end else begin
          pc_load    = jump_taken;
          pc_inc     = ~jump_taken;
          state_next = step_rise ? S_FETCH : S_HOLD;
        end
      end
      S_HOLD: begin
        running = 1'b1;
        phase   = PH_COMMIT;
        if (step_rise) state_next = S_FETCH;
      end
      S_HALTED: begin
        done = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// tb/tb_fetch_exec_sequencer.sv - randomized self-checking bench for fetch_exec_sequencer
module tb_fetch_exec_sequencer;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mem_busy = 1'b0;
  logic        halt_ins = 1'b0;
  logic        jump_taken = 1'b0;
  logic        step = 1'b0;
  logic [1:0]  phase;
  logic        ir_load, exec_en, pc_load, pc_inc, running, done;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  int model_ret = 0;

  // One expected cycle: inputs to drive and outputs the spec demands.
  typedef struct {
    logic       busy, halt, jump, start, step;
    logic [1:0] ph;
    logic       ir, ex, pl, pi, run, dn;
    int         ret;
  } cyc_t;

  cyc_t tr[$];

  fetch_exec_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mem_busy(mem_busy),
    .halt_ins(halt_ins), .jump_taken(jump_taken),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .phase(phase), .ir_load(ir_load), .exec_en(exec_en), .pc_load(pc_load),
    .pc_inc(pc_inc), .running(running), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic cyc_t base_e();
    cyc_t e;
    e.busy  = 1'($urandom_range(0, 1));
    e.halt  = 1'($urandom_range(0, 1));
    e.jump  = 1'($urandom_range(0, 1));
    e.start = 1'($urandom_range(0, 1));
    e.step  = 1'b0;
    e.ph    = PH_FETCH;
    e.ir    = 1'b0; e.ex = 1'b0; e.pl = 1'b0; e.pi = 1'b0;
    e.run   = 1'b0; e.dn = 1'b0;
    e.ret   = model_ret;
    return e;
  endfunction

  task automatic add_start();
    cyc_t e;
    e = base_e();
    e.start = 1'b1;
    tr.push_back(e);
  endtask

  task automatic add_halted(int n);
    cyc_t e;
    for (int i = 0; i < n; i++) begin
      e = base_e();
      e.dn = 1'b1;
      tr.push_back(e);
    end
  endtask

  // One instruction: fs FETCH stall cycles, es EXEC stall cycles, hold = step-hold cycles.
  task automatic add_instr(int fs, int es, bit j, bit h, int hold);
    cyc_t e;
    for (int i = 0; i < fs; i++) begin
      e = base_e(); e.busy = 1'b1; e.run = 1'b1; tr.push_back(e);
    end
    e = base_e(); e.busy = 1'b0; e.run = 1'b1; e.ir = 1'b1; tr.push_back(e);
    e = base_e(); e.run = 1'b1; e.ph = PH_DECODE; tr.push_back(e);
    for (int i = 0; i < es; i++) begin
      e = base_e(); e.busy = 1'b1; e.run = 1'b1; e.ph = PH_EXEC; tr.push_back(e);
    end
    e = base_e(); e.busy = 1'b0; e.run = 1'b1; e.ph = PH_EXEC; e.ex = 1'b1; tr.push_back(e);
    e = base_e(); e.run = 1'b1; e.ph = PH_COMMIT; e.halt = h; e.jump = j;
    e.pl = !h && j; e.pi = !h && !j;
`ifdef SINGLE_STEP_EN
    if (!h) e.step = (hold == 0);
`endif
    tr.push_back(e);
    model_ret++;
`ifdef SINGLE_STEP_EN
    if (!h) begin
      for (int k = 1; k <= hold; k++) begin
        e = base_e(); e.halt = 1'b0; e.run = 1'b1; e.ph = PH_COMMIT; e.step = (k == hold);
        tr.push_back(e);
      end
    end
`else
    if (hold < 0) model_ret = model_ret;
`endif
  endtask

  task automatic replay(string name, int n);
    cyc_t e;
    for (int i = 0; i < n; i++) begin
      e = tr[i];
      @(posedge clk);
      #1;
      mem_busy = e.busy; halt_ins = e.halt; jump_taken = e.jump;
      start = e.start; step = e.step;
      #1;
      checks++;
      if ({phase, ir_load, exec_en, pc_load, pc_inc, running, done} !==
          {e.ph, e.ir, e.ex, e.pl, e.pi, e.run, e.dn}) begin
        errors++;
        $display("FAIL %s cyc %0d {phase,ir,ex,pl,pi,run,done} got %b want %b", name, i,
                 {phase, ir_load, exec_en, pc_load, pc_inc, running, done},
                 {e.ph, e.ir, e.ex, e.pl, e.pi, e.run, e.dn});
      end
      checks++;
      if (retired !== 16'(e.ret)) begin
        errors++;
        $display("FAIL %s cyc %0d retired got %0d want %0d", name, i, retired, e.ret);
      end
    end
    start = 1'b0; step = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; mem_busy = 1'b0; halt_ins = 1'b0;
    jump_taken = 1'b0; step = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_ret = 0;
    tr.delete();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({phase, ir_load, exec_en, pc_load, pc_inc, running, done, retired} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {phase, ir_load, exec_en, pc_load, pc_inc, running, done, retired});
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc_t e;
      e = base_e(); e.start = 1'b0; tr.push_back(e);
    end
    replay("idle", tr.size());
  endtask

  task automatic test_plain();
    do_reset();
    add_start();
    for (int i = 0; i < 3; i++) add_instr(0, 0, 1'b0, 1'b0, 0);
    replay("plain", tr.size());
    @(posedge clk);
    #1 mem_busy = 1'b0;
    #1;
    checks++;
    if (retired !== 16'd3 || phase !== PH_FETCH || ir_load !== 1'b1) begin
      errors++;
      $display("FAIL plain_end retired/phase/ir got %0d/%b/%b want 3/00/1", retired, phase, ir_load);
    end
  endtask

  task automatic test_stalls();
    do_reset();
    add_start();
    add_instr(3, 0, 1'b0, 1'b0, 0);
    add_instr(0, 3, 1'b0, 1'b0, 0);
    add_instr(2, 2, 1'b1, 1'b0, 1);
    replay("stalls", tr.size());
  endtask

  task automatic test_jump();
    do_reset();
    add_start();
    add_instr(0, 0, 1'b1, 1'b0, 0);
    add_instr(1, 1, 1'b1, 1'b1, 0);
    add_halted(3);
    replay("jump", tr.size());
  endtask

  task automatic test_halt();
    do_reset();
    add_start();
    for (int i = 0; i < 4; i++) add_instr(0, 0, 1'b0, 1'b0, 0);
    add_instr(0, 0, 1'b0, 1'b1, 0);
    add_halted(2);
    tr[tr.size()-1].start = 1'b1;
    add_halted(3);
    replay("halt", tr.size());
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || retired !== 16'd5) begin
      errors++;
      $display("FAIL halt_final done/running/retired got %b/%b/%0d want 1/0/5", done, running, retired);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n;
      do_reset();
      add_start();
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++)
        add_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  (i == n - 1), $urandom_range(0, 3));
      add_halted(2);
      replay("random", tr.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    add_start();
    add_instr(0, 0, 1'b0, 1'b0, 0);
    add_instr(0, 0, 1'b0, 1'b0, 0);
    replay("async_pre", 8);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({phase, ir_load, exec_en, pc_load, pc_inc, running, done, retired} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset got %b want 0",
               {phase, ir_load, exec_en, pc_load, pc_inc, running, done, retired});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (running !== 1'b0 || phase !== PH_FETCH || pc_inc !== 1'b0 || pc_load !== 1'b0
        || retired !== 16'd0) begin
      errors++;
      $display("FAIL async_release run/phase/pi/pl/ret got %b/%b/%b/%b/%0d want 0/00/0/0/0",
               running, phase, pc_inc, pc_load, retired);
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    do_reset();
    add_start();
    add_instr(0, 0, 1'b0, 1'b0, 6);
    add_instr(0, 0, 1'b1, 1'b0, 2);
    add_instr(1, 0, 1'b0, 1'b0, 3);
    add_instr(0, 0, 1'b0, 1'b1, 0);
    add_halted(2);
    replay("step", tr.size());
  endtask
`endif

  initial begin
    test_reset();
    test_plain();
    test_stalls();
    test_jump();
    test_halt();
    test_random();
    test_async_reset();
`ifdef SINGLE_STEP_EN
    test_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
